servo_setpoint_ctrl: RTL and testbench

- Upstream command stage for the servo PWM channel: turns raw inc/dec push-buttons into a saturated 16-bit pulse-width setpoint in microseconds.
- Synchronises and debounces both buttons, then steps the setpoint at a fixed rate with hold-to-repeat behaviour.
- Also provides "both pressed → return to centre" and limit indicators.
- pulse_width feeds the PWM channel directly (1 µs units, 2500 µs frame).

---
 rtl/servo_setpoint_ctrl.sv | 141 ++++++++++++++
 tb/tb_servo_setpoint_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_setpoint_ctrl.sv
// Servo setpoint command stage: debounced inc/dec buttons step a clamped pulse width.
// Define SERVO_SETPOINT_HOLD_ACCEL_EN to switch to 4*STEP after ACCEL_TICKS held ticks.

module servo_setpoint_dbnc #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            lvl  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                lvl <= ~lvl;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module servo_setpoint_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int STEP_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MIN_VAL         = 1000,
    parameter int MAX_VAL         = 2000,
    parameter int STEP            = 1,
    parameter int ACCEL_TICKS     = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] pulse_width,
    output logic        update,
    output logic        at_max,
    output logic        at_min
);
    localparam int NUM_BTN  = 2;
    localparam int MID      = (MIN_VAL + MAX_VAL) / 2;
    localparam int TICK_DIV = CLK_HZ / STEP_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (MIN_VAL >= MAX_VAL || MAX_VAL > 65535 || ACCEL_TICKS < 1 || TICK_DIV < 2)
        $error("servo_setpoint_ctrl: bad parameters");

    typedef enum logic [1:0] {IDLE, INC, DEC, CENTER} state_t;

    logic [NUM_BTN-1:0] raw_btn, db_btn;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    state_t             state;
    logic [16:0]        step17, cur17;
    logic [15:0]        nxt_pw;

    assign raw_btn = {dec, inc};

    servo_setpoint_dbnc #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc [NUM_BTN-1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_btn),
        .lvl   (db_btn)
    );

    // Free-running step timebase; button activity never resyncs it.
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt <= '0;
        else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

`ifdef SERVO_SETPOINT_HOLD_ACCEL_EN
    localparam int AW = $clog2(ACCEL_TICKS + 1);
    logic [AW-1:0] held_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            held_cnt <= '0;
        else if (state != INC && state != DEC)
            held_cnt <= '0;
        else if (tick && held_cnt != AW'(ACCEL_TICKS))
            held_cnt <= held_cnt + 1'b1;
    end

    assign step17 = (held_cnt == AW'(ACCEL_TICKS)) ? 17'(4 * STEP) : 17'(STEP);
`else
    assign step17 = 17'(STEP);
`endif

    // 17-bit headroom keeps the clamp honest at both ends of the 16-bit range.
    assign cur17 = {1'b0, pulse_width};

    always_comb begin
        nxt_pw = pulse_width;
        if (tick) begin
            case (state)
                INC:     nxt_pw = (cur17 + step17 > 17'(MAX_VAL)) ? 16'(MAX_VAL) : 16'(cur17 + step17);
                DEC:     nxt_pw = (cur17 < 17'(MIN_VAL) + step17) ? 16'(MIN_VAL) : 16'(cur17 - step17);
                CENTER:  nxt_pw = 16'(MID);
                default: nxt_pw = pulse_width;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pulse_width <= 16'(MID);
            update      <= 1'b0;
            at_max      <= 1'b0;
            at_min      <= 1'b0;
        end else begin
            case (db_btn)
                2'b01:   state <= INC;
                2'b10:   state <= DEC;
                2'b11:   state <= CENTER;
                default: state <= IDLE;
            endcase
            pulse_width <= nxt_pw;
            update      <= (nxt_pw != pulse_width);
            at_max      <= (nxt_pw == 16'(MAX_VAL));
            at_min      <= (nxt_pw == 16'(MIN_VAL));
        end
    end
endmodule

// File: tb/tb_servo_setpoint_ctrl.sv
// Scoreboard bench for servo_setpoint_ctrl: a reference model queues every expected
// setpoint change and a negedge monitor matches them against update strobes.

module tb_servo_setpoint_ctrl;
    localparam int CLK_HZ = 1000, STEP_HZ = 100, DEB = 4;
    localparam int MINV = 1000, MAXV = 2000, MID = 1500, ACC = 5;
    localparam int TDIV = CLK_HZ / STEP_HZ;

    logic        clk = 0, rst_n = 0, inc = 0, dec = 0;
    logic [15:0] pulse_width;
    logic        update, at_max, at_min;

    int vectors = 0, errors = 0;

    typedef struct {int pw; bit mx; bit mn;} exp_t;
    exp_t exp_q[$];

    servo_setpoint_ctrl #(
        .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .DEBOUNCE_CYCLES(DEB),
        .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP(1), .ACCEL_TICKS(ACC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
        .pulse_width(pulse_width), .update(update), .at_max(at_max), .at_min(at_min)
    );

    always #5 clk = ~clk;

    // Reference model: a button is accepted once the (two-edge-late) input has
    // disagreed with the accepted level for DEB edges in a row; every TDIV-th edge
    // the previously accepted mode moves the setpoint.
    int m_pw, m_cyc, m_mode, m_held;
    bit m_seen [2][3];
    bit m_acc [2];
    int m_run [2];

    always @(posedge clk or negedge rst_n) begin
        bit raw [2];
        bit is_tick;
        int step, nv;
        if (!rst_n) begin
            m_pw = MID; m_cyc = 0; m_mode = 0; m_held = 0;
            for (int b = 0; b < 2; b++) begin
                m_acc[b] = 0; m_run[b] = 0;
                for (int k = 0; k < 3; k++) m_seen[b][k] = 0;
            end
            exp_q.delete();
        end else begin
            raw[0] = inc; raw[1] = dec;
            is_tick = (m_cyc % TDIV) == TDIV - 1;
            m_cyc++;
            nv = m_pw;
            if (m_mode == 1 || m_mode == 2) begin
                if (is_tick) begin
                    step = 1;
`ifdef SERVO_SETPOINT_HOLD_ACCEL_EN
                    if (m_held >= ACC) step = 4;
`endif
                    if (m_held < ACC) m_held++;
                    if (m_mode == 1) nv = (m_pw + step > MAXV) ? MAXV : m_pw + step;
                    else             nv = (m_pw - step < MINV) ? MINV : m_pw - step;
                end
            end else begin
                m_held = 0;
                if (is_tick && m_mode == 3) nv = MID;
            end
            if (nv != m_pw) exp_q.push_back('{nv, nv == MAXV, nv == MINV});
            m_pw = nv;
            m_mode = (m_acc[0] && m_acc[1]) ? 3 : m_acc[0] ? 1 : m_acc[1] ? 2 : 0;
            for (int b = 0; b < 2; b++) begin
                m_seen[b][2] = m_seen[b][1];
                m_seen[b][1] = m_seen[b][0];
                m_seen[b][0] = raw[b];
                if (m_seen[b][2] != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_acc[b] = ~m_acc[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            vectors++;
            if (at_max !== (pulse_width == MAXV) || at_min !== (pulse_width == MINV)) begin
                errors++;
                $display("FAIL flags: pw=%0d at_max=%b at_min=%b", pulse_width, at_max, at_min);
            end
            if (update) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: pw=%0d, no change expected", pulse_width);
                end else begin
                    e = exp_q.pop_front();
                    if (pulse_width !== 16'(e.pw) || at_max !== e.mx || at_min !== e.mn) begin
                        errors++;
                        $display("FAIL update_value: got pw=%0d max=%b min=%b expected pw=%0d max=%b min=%b",
                                 pulse_width, at_max, at_min, e.pw, e.mx, e.mn);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++; errors++;
                $display("FAIL missing_update: pw=%0d expected new value %0d", pulse_width, e.pw);
            end
            vectors++;
            if (pulse_width !== 16'(m_pw)) begin
                errors++;
                $display("FAIL track: pw=%0d expected %0d", pulse_width, m_pw);
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic wait_pw(input string name, input int target, input int limit);
        int n = 0;
        while (pulse_width != 16'(target) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, pulse_width, target);
    endtask

    task automatic count_updates(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (update) n++;
        end
    endtask

    initial begin
        int n, lat, pw0;
        repeat (3) @(negedge clk);
        chk("reset_pw", pulse_width, MID);
        chk("reset_at_max", at_max, 0);
        chk("reset_at_min", at_min, 0);
        chk("reset_update", update, 0);
        rst_n = 1;

        count_updates(200, n);
        chk("idle_updates", n, 0);

        // First step latency after a press
        inc = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!update && lat < 25);
        chk("first_step_pw", pulse_width, MID + 1);
        chk("first_step_window", int'(lat >= 8 && lat <= 2 + DEB + TDIV + 1), 1);
        pw0 = pulse_width;
        count_updates(100 - lat, n);
        chk("hold_inc_rate", int'(pulse_width) - pw0, n);

        // Upper limit
        wait_pw("reach_max", MAXV, 6000);
        chk("at_max_set", at_max, 1);
        count_updates(40, n);
        chk("max_no_update", n, 0);
        chk("max_hold", pulse_width, MAXV);
        inc = 0;
        repeat (10) @(negedge clk);
        dec = 1;
        wait_pw("dec_from_max", MAXV - 1, 40);
        chk("at_max_clear", at_max, 0);

        // Down to 1700, then centre with both buttons
        wait_pw("reach_1700", 1700, 4000);
        dec = 0;
        repeat (20) @(negedge clk);
        inc = 1; dec = 1;
        wait_pw("center", MID, 40);
        count_updates(50, n);
        chk("center_hold_no_update", n, 0);
        inc = 0; dec = 0;
        repeat (20) @(negedge clk);

        // Short pulses must never be accepted
        n = 0;
        repeat (10) begin
            inc = 1;
            repeat (3) begin @(negedge clk); if (update) n++; end
            inc = 0;
            repeat (3) begin @(negedge clk); if (update) n++; end
        end
        repeat (20) begin @(negedge clk); if (update) n++; end
        chk("glitch_no_update", n, 0);
        chk("glitch_pw", pulse_width, MID);

        // Lower limit
        dec = 1;
        wait_pw("reach_min", MINV, 6000);
        chk("at_min_set", at_min, 1);
        count_updates(30, n);
        chk("min_no_update", n, 0);
        dec = 0;
        repeat (20) @(negedge clk);
        inc = 1;
        wait_pw("back_to_mid", MID, 6000);

        // Asynchronous reset mid-hold
        wait_pw("reach_1620", 1620, 1500);
        #2 rst_n = 0;
        #1;
        chk("async_reset_pw", pulse_width, MID);
        chk("async_reset_update", update, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (200) @(negedge clk);
        inc = 0;
        repeat (20) @(negedge clk);

        // Random button activity
        repeat (60) begin
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        inc = 0; dec = 0;
        repeat (40) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
